// File: rtl/apb_global_pkg.sv
// ---------------------------------------------------------------------------
// apb_global_pkg
// Shared types and default sizes for the APB4 completer and its local memory.
//   ADDRESS_WIDTH / DATA_WIDTH : default bus widths
//   SLAVE_MEMORY_SIZE          : default memory size in KB
//   MEMORY_WIDTH               : memory granularity (one byte per entry)
//   apb_fsm_state_e            : completer state encoding seen on fsm_state
//   tx_type_e / slave_error_e  : transfer direction and response kinds
// ---------------------------------------------------------------------------
package apb_global_pkg;

   localparam int ADDRESS_WIDTH     = 32;
   localparam int DATA_WIDTH        = 32;
   localparam int SLAVE_MEMORY_SIZE = 12;
   localparam int MEMORY_WIDTH      = 8;

   typedef enum logic [2:0] {
      APB_IDLE       = 3'd0,
      APB_SETUP      = 3'd1,
      APB_WAIT_STATE = 3'd2,
      APB_ACCESS     = 3'd3
   } apb_fsm_state_e;

   typedef enum logic {
      TX_READ  = 1'b0,
      TX_WRITE = 1'b1
   } tx_type_e;

   typedef enum logic {
      SLV_OKAY  = 1'b0,
      SLV_ERROR = 1'b1
   } slave_error_e;

endpackage

// File: rtl/apb_slave_responder_if.sv
// ---------------------------------------------------------------------------
// apb_slave_responder_if
// APB4 bus signals between one requester and one completer.
//   master modport : drives psel/penable/pwrite/paddr/pwdata/pstrb/pprot,
//                    receives pready/prdata/pslverr
//   slave modport  : the mirror image
// ---------------------------------------------------------------------------
interface apb_slave_responder_if #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32
);

   logic                      psel;
   logic                      penable;
   logic                      pwrite;
   logic [ADDRESS_WIDTH-1:0]  paddr;
   logic [DATA_WIDTH-1:0]     pwdata;
   logic [DATA_WIDTH/8-1:0]   pstrb;
   logic [2:0]                pprot;
   logic                      pready;
   logic [DATA_WIDTH-1:0]     prdata;
   logic                      pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
      output pready, prdata, pslverr
   );

endinterface

// File: rtl/apb_slave_memory.sv
// ---------------------------------------------------------------------------
// apb_slave_memory
// Byte-organised storage for the APB completer. Contents are not reset.
//   clk   : write clock (rising edge)
//   wr_en : commit wdata to the lanes selected by strb
//   addr  : byte index of the aligned word (lane 0)
//   wdata : write word, lane i -> mem[addr+i] (little endian)
//   strb  : per-lane write enables
//   rdata : combinational read of the aligned word at addr
// ---------------------------------------------------------------------------
module apb_slave_memory
   import apb_global_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_BYTES  = 12288
) (
   input  logic                                 clk,
   input  logic                                 wr_en,
   input  logic [$clog2(MEM_BYTES)-1:0]         addr,
   input  logic [DATA_WIDTH-1:0]                wdata,
   input  logic [DATA_WIDTH/MEMORY_WIDTH-1:0]   strb,
   output logic [DATA_WIDTH-1:0]                rdata
);

   localparam int LANES = DATA_WIDTH / MEMORY_WIDTH;
   localparam int IDX_W = $clog2(MEM_BYTES);

   logic [MEMORY_WIDTH-1:0] mem [MEM_BYTES];

   // strobed per-lane write
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < LANES; i++) begin
            if (strb[i]) begin
               mem[addr + IDX_W'(i)] <= wdata[i*MEMORY_WIDTH +: MEMORY_WIDTH];
            end
         end
      end
   end

   // assemble the aligned word from its byte lanes
   always_comb begin
      rdata = {DATA_WIDTH{1'b0}};
      for (int i = 0; i < LANES; i++) begin
         rdata[i*MEMORY_WIDTH +: MEMORY_WIDTH] = mem[addr + IDX_W'(i)];
      end
   end

endmodule

// File: rtl/apb_slave_responder.sv
// ---------------------------------------------------------------------------
// apb_slave_responder
// APB4 completer: one decoded address window backed by byte memory, a
// programmable number of wait states per transfer, PSLVERR on bad accesses.
//   pclk            : bus clock, rising edge
//   preset          : synchronous reset, active high (memory is not reset)
//   bus             : APB signals (slave modport)
//   wait_states_cfg : wait states applied to the transfer whose setup edge samples it
//   fsm_state       : current apb_fsm_state_e encoding
// ---------------------------------------------------------------------------
module apb_slave_responder
   import apb_global_pkg::*;
#(
   parameter int                          ADDRESS_WIDTH     = apb_global_pkg::ADDRESS_WIDTH,
   parameter int                          DATA_WIDTH        = apb_global_pkg::DATA_WIDTH,
   parameter int                          SLAVE_MEMORY_SIZE = apb_global_pkg::SLAVE_MEMORY_SIZE,
   parameter logic [ADDRESS_WIDTH-1:0]    MIN_ADDRESS       = '0,
   parameter int                          WAIT_WIDTH        = 4,
   parameter bit                          PROT_CHECK        = 1'b0
) (
   input  logic                    pclk,
   input  logic                    preset,
   apb_slave_responder_if.slave    bus,
   input  logic [WAIT_WIDTH-1:0]   wait_states_cfg,
   output logic [2:0]              fsm_state
);

   localparam int LANES     = DATA_WIDTH / MEMORY_WIDTH;
   localparam int MEM_BYTES = SLAVE_MEMORY_SIZE * 1024;
   localparam int IDX_W     = $clog2(MEM_BYTES);

   localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_WIDTH'(LANES - 1);
   // One extra bit so the window end check never wraps at the top of the address space.
   localparam logic [ADDRESS_WIDTH:0]   LANE_SPAN  = (ADDRESS_WIDTH+1)'(LANES - 1);
   localparam logic [ADDRESS_WIDTH:0]   LAST_BYTE  = {1'b0, MIN_ADDRESS} + (ADDRESS_WIDTH+1)'(MEM_BYTES - 1);

   localparam logic [2:0] ST_IDLE   = APB_IDLE;
   localparam logic [2:0] ST_SETUP  = APB_SETUP;
   localparam logic [2:0] ST_WAIT   = APB_WAIT_STATE;
   localparam logic [2:0] ST_ACCESS = APB_ACCESS;

   logic [2:0]               state_r;
   logic [WAIT_WIDTH-1:0]    cnt_r;
   logic                     pready_r;
   logic                     pslverr_r;
   logic [DATA_WIDTH-1:0]    prdata_r;
   logic [ADDRESS_WIDTH-1:0] addr_r;
   logic                     write_r;
   logic [DATA_WIDTH-1:0]    wdata_r;
   logic [LANES-1:0]         strb_r;
   logic                     nonsecure_r;

   logic                     setup_s;
   logic                     access_s;
   logic                     in_xfer_s;
   logic [ADDRESS_WIDTH-1:0] addr_sel_s;
   logic                     write_sel_s;
   logic                     nonsecure_sel_s;
   logic [ADDRESS_WIDTH-1:0] aligned_s;
   logic                     err_s;
   logic [IDX_W-1:0]         mem_idx_s;
   logic [DATA_WIDTH-1:0]    mem_rdata_s;
   logic [DATA_WIDTH-1:0]    rd_word_s;
   logic                     wr_en_s;

   // decode, error check and write commit for the transfer in flight
   always_comb begin
      setup_s   = bus.psel && !bus.penable;
      access_s  = bus.psel && bus.penable;
      in_xfer_s = (state_r == ST_SETUP) || (state_r == ST_WAIT);
      // A zero-wait transfer produces its response on the setup edge itself,
      // before the latches are loaded, so the live bus values are used there.
      if (setup_s) begin
         addr_sel_s      = bus.paddr;
         write_sel_s     = bus.pwrite;
         nonsecure_sel_s = bus.pprot[1];
      end else begin
         addr_sel_s      = addr_r;
         write_sel_s     = write_r;
         nonsecure_sel_s = nonsecure_r;
      end
      aligned_s = addr_sel_s & ALIGN_MASK;
      err_s     = (aligned_s < MIN_ADDRESS)
               || (({1'b0, aligned_s} + LANE_SPAN) > LAST_BYTE)
               || (PROT_CHECK && nonsecure_sel_s);
      mem_idx_s = IDX_W'(aligned_s - MIN_ADDRESS);
      if (err_s || write_sel_s) begin
         rd_word_s = {DATA_WIDTH{1'b0}};
      end else begin
         rd_word_s = mem_rdata_s;
      end
      wr_en_s = in_xfer_s && access_s && pready_r && write_r && !err_s && !preset;
   end

   // transfer FSM, wait counter and registered response
   always_ff @(posedge pclk) begin
      if (preset) begin
         state_r     <= ST_IDLE;
         cnt_r       <= {WAIT_WIDTH{1'b0}};
         pready_r    <= 1'b0;
         pslverr_r   <= 1'b0;
         prdata_r    <= {DATA_WIDTH{1'b0}};
         addr_r      <= {ADDRESS_WIDTH{1'b0}};
         write_r     <= 1'b0;
         wdata_r     <= {DATA_WIDTH{1'b0}};
         strb_r      <= {LANES{1'b0}};
         nonsecure_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_ACCESS: begin
               if (setup_s) begin
                  addr_r      <= bus.paddr;
                  write_r     <= bus.pwrite;
                  wdata_r     <= bus.pwdata;
                  strb_r      <= bus.pstrb;
                  nonsecure_r <= bus.pprot[1];
                  cnt_r       <= wait_states_cfg;
                  pready_r    <= (wait_states_cfg == {WAIT_WIDTH{1'b0}});
                  if (wait_states_cfg == {WAIT_WIDTH{1'b0}}) begin
                     pslverr_r <= err_s;
                     prdata_r  <= rd_word_s;
                  end else begin
                     pslverr_r <= 1'b0;
                     prdata_r  <= {DATA_WIDTH{1'b0}};
                  end
                  state_r <= ST_SETUP;
               end else begin
                  pready_r  <= 1'b0;
                  pslverr_r <= 1'b0;
                  prdata_r  <= {DATA_WIDTH{1'b0}};
                  state_r   <= ST_IDLE;
               end
            end
            ST_SETUP, ST_WAIT: begin
               if (access_s) begin
                  if (pready_r) begin
                     // completion edge: the memory write happens in parallel via wr_en_s
                     pready_r  <= 1'b0;
                     pslverr_r <= 1'b0;
                     prdata_r  <= {DATA_WIDTH{1'b0}};
                  end else begin
                     cnt_r    <= cnt_r - WAIT_WIDTH'(1);
                     pready_r <= (cnt_r == WAIT_WIDTH'(1));
                     if (cnt_r == WAIT_WIDTH'(1)) begin
                        pslverr_r <= err_s;
                        prdata_r  <= rd_word_s;
                     end else begin
                        pslverr_r <= 1'b0;
                        prdata_r  <= {DATA_WIDTH{1'b0}};
                     end
                  end
                  // The counter has reached zero exactly on the completion edge.
                  if (cnt_r == {WAIT_WIDTH{1'b0}}) begin
                     state_r <= ST_ACCESS;
                  end else begin
                     state_r <= ST_WAIT;
                  end
               end else begin
                  // requester dropped psel/penable before completion: abandon it
                  state_r   <= ST_IDLE;
                  cnt_r     <= {WAIT_WIDTH{1'b0}};
                  pready_r  <= 1'b0;
                  pslverr_r <= 1'b0;
                  prdata_r  <= {DATA_WIDTH{1'b0}};
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               cnt_r     <= {WAIT_WIDTH{1'b0}};
               pready_r  <= 1'b0;
               pslverr_r <= 1'b0;
               prdata_r  <= {DATA_WIDTH{1'b0}};
            end
         endcase
      end
   end

   assign bus.pready  = pready_r;
   assign bus.pslverr = pslverr_r;
   assign bus.prdata  = prdata_r;
   assign fsm_state   = state_r;

   apb_slave_memory #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_BYTES  (MEM_BYTES)
   ) u_mem (
      .clk   (pclk),
      .wr_en (wr_en_s),
      .addr  (mem_idx_s),
      .wdata (wdata_r),
      .strb  (strb_r),
      .rdata (mem_rdata_s)
   );

endmodule

// File: tb/tb_apb_slave_responder.sv
// ---------------------------------------------------------------------------
// tb_apb_slave_responder
// Two completers share one stimulus stream: dut0 checks pprot, dut1 does not.
// Expected responses are queued when a transfer is issued and compared by a
// separate monitor whenever dut0 raises pready.
// ---------------------------------------------------------------------------
module tb_apb_slave_responder;

   typedef struct {
      logic        wr;
      logic [31:0] rd0;
      logic        e0;
      logic [31:0] rd1;
      logic        e1;
      int          waits;
   } exp_t;

   logic       pclk = 1'b0;
   logic       preset;
   logic [3:0] wait_cfg;
   logic [2:0] fsm0;
   logic [2:0] fsm1;

   int   pass_cnt  = 0;
   int   total_cnt = 0;
   int   cyc       = 0;
   exp_t sb[$];
   exp_t mon_e;

   apb_slave_responder_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
   apb_slave_responder_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

   assign bus1.psel    = bus0.psel;
   assign bus1.penable = bus0.penable;
   assign bus1.pwrite  = bus0.pwrite;
   assign bus1.paddr   = bus0.paddr;
   assign bus1.pwdata  = bus0.pwdata;
   assign bus1.pstrb   = bus0.pstrb;
   assign bus1.pprot   = bus0.pprot;

   apb_slave_responder #(
      .MIN_ADDRESS (32'h0000_0000),
      .WAIT_WIDTH  (4),
      .PROT_CHECK  (1'b1)
   ) dut0 (
      .pclk            (pclk),
      .preset          (preset),
      .bus             (bus0),
      .wait_states_cfg (wait_cfg),
      .fsm_state       (fsm0)
   );

   apb_slave_responder #(
      .MIN_ADDRESS (32'h0000_0000),
      .WAIT_WIDTH  (4),
      .PROT_CHECK  (1'b0)
   ) dut1 (
      .pclk            (pclk),
      .preset          (preset),
      .bus             (bus1),
      .wait_states_cfg (wait_cfg),
      .fsm_state       (fsm1)
   );

   always #5 pclk = ~pclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // one complete APB transfer; expectation is queued before the bus moves
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [2:0] prot, input int waits,
                       input logic [31:0] rd0, input logic e0,
                       input logic [31:0] rd1, input logic e1);
      exp_t x;
      int   k;
      x.wr = wr; x.rd0 = rd0; x.e0 = e0; x.rd1 = rd1; x.e1 = e1; x.waits = waits;
      sb.push_back(x);
      @(posedge pclk); #1;
      bus0.psel    = 1'b1;
      bus0.penable = 1'b0;
      bus0.pwrite  = wr;
      bus0.paddr   = addr;
      bus0.pwdata  = wdata;
      bus0.pstrb   = strb;
      bus0.pprot   = prot;
      wait_cfg     = 4'(waits);
      @(posedge pclk); #1;
      bus0.penable = 1'b1;
      // access-phase changes must be ignored by the completer
      bus0.paddr   = addr ^ 32'h0000_0004;
      bus0.pwdata  = ~wdata;
      wait_cfg     = ~4'(waits);
      k = 0;
      while (!bus0.pready && k < 40) begin
         @(posedge pclk); #1;
         k++;
      end
      if (k >= 40) begin
         total_cnt++;
         $display("FAIL pready_timeout: addr %h got no pready within 40 cycles", addr);
      end
      @(posedge pclk); #1;
      bus0.psel    = 1'b0;
      bus0.penable = 1'b0;
   endtask

   // scoreboard monitor: compares each completed transfer of both completers
   always @(negedge pclk) begin
      if (preset === 1'b0) begin
         if (bus0.psel && !bus0.penable) begin
            cyc = 1;
         end else if (bus0.psel && bus0.penable) begin
            cyc++;
         end
         if (bus0.pready === 1'b1) begin
            if (sb.size() == 0) begin
               total_cnt++;
               $display("FAIL sb_underflow: pready with no queued expectation");
            end else begin
               mon_e = sb.pop_front();
               check("xfer_cycles", 32'(cyc), 32'(mon_e.waits + 2));
               check("pslverr0", {31'd0, bus0.pslverr}, {31'd0, mon_e.e0});
               check("pready1", {31'd0, bus1.pready}, 32'd1);
               check("pslverr1", {31'd0, bus1.pslverr}, {31'd0, mon_e.e1});
               if (!mon_e.wr) begin
                  check("prdata0", bus0.prdata, mon_e.rd0);
                  check("prdata1", bus1.prdata, mon_e.rd1);
               end
            end
         end
      end
   end

   initial begin
      preset       = 1'b1;
      bus0.psel    = 1'b0;
      bus0.penable = 1'b0;
      bus0.pwrite  = 1'b0;
      bus0.paddr   = 32'h0;
      bus0.pwdata  = 32'h0;
      bus0.pstrb   = 4'h0;
      bus0.pprot   = 3'b000;
      wait_cfg     = 4'd0;
      repeat (3) @(posedge pclk);
      #1;
      check("rst_pready", {31'd0, bus0.pready}, 32'd0);
      check("rst_pslverr", {31'd0, bus0.pslverr}, 32'd0);
      check("rst_prdata", bus0.prdata, 32'd0);
      check("rst_fsm", {29'd0, fsm0}, 32'd0);
      preset = 1'b0;

      //   wr    addr           wdata          strb   prot    w  rd0            e0    rd1            e1
      xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF,  3'b000, 0, 32'h0,         1'b0, 32'h0,         1'b0);
      xfer(1'b0, 32'h0000_0010, 32'h0,         4'h0,  3'b000, 0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0);
      xfer(1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF,  3'b000, 1, 32'h0,         1'b0, 32'h0,         1'b0);
      xfer(1'b1, 32'h0000_0020, 32'h1122_3344, 4'h5,  3'b000, 2, 32'h0,         1'b0, 32'h0,         1'b0);
      xfer(1'b0, 32'h0000_0020, 32'h0,         4'hF,  3'b000, 0, 32'hFF22_FF44, 1'b0, 32'hFF22_FF44, 1'b0);
      xfer(1'b0, 32'h0000_0013, 32'h0,         4'h0,  3'b000, 3, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0);
      xfer(1'b1, 32'h0000_2FFC, 32'h0BAD_CAFE, 4'hF,  3'b000, 1, 32'h0,         1'b0, 32'h0,         1'b0);
      xfer(1'b0, 32'h0000_2FFE, 32'h0,         4'h0,  3'b000, 0, 32'h0BAD_CAFE, 1'b0, 32'h0BAD_CAFE, 1'b0);
      xfer(1'b1, 32'h0000_3000, 32'h55AA_55AA, 4'hF,  3'b000, 2, 32'h0,         1'b1, 32'h0,         1'b1);
      xfer(1'b0, 32'h0000_3000, 32'h0,         4'h0,  3'b000, 1, 32'h0,         1'b1, 32'h0,         1'b1);
      xfer(1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 4'hF,  3'b000, 0, 32'h0,         1'b1, 32'h0,         1'b1);
      xfer(1'b0, 32'h0000_2FFC, 32'h0,         4'h0,  3'b000, 0, 32'h0BAD_CAFE, 1'b0, 32'h0BAD_CAFE, 1'b0);
      // non-secure write rejected only by the completer that checks pprot
      xfer(1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 4'hF,  3'b000, 0, 32'h0,         1'b0, 32'h0,         1'b0);
      xfer(1'b1, 32'h0000_0040, 32'h5A5A_5A5A, 4'hF,  3'b010, 1, 32'h0,         1'b1, 32'h0,         1'b0);
      xfer(1'b0, 32'h0000_0040, 32'h0,         4'h0,  3'b000, 0, 32'hA5A5_A5A5, 1'b0, 32'h5A5A_5A5A, 1'b0);
      xfer(1'b0, 32'h0000_0010, 32'h0,         4'h0,  3'b010, 2, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0);
      xfer(1'b0, 32'h0000_0010, 32'h0,         4'h0,  3'b000, 0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0);
      xfer(1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'hF,  3'b000, 0, 32'h0,         1'b0, 32'h0,         1'b0);

      // reset in the middle of a waited write
      @(posedge pclk); #1;
      bus0.psel    = 1'b1;
      bus0.penable = 1'b0;
      bus0.pwrite  = 1'b1;
      bus0.paddr   = 32'h0000_0030;
      bus0.pwdata  = 32'h1234_5678;
      bus0.pstrb   = 4'hF;
      bus0.pprot   = 3'b000;
      wait_cfg     = 4'd5;
      @(posedge pclk); #1;
      bus0.penable = 1'b1;
      @(posedge pclk); #1;
      check("wait_fsm", {29'd0, fsm0}, 32'd2);
      check("wait_pready", {31'd0, bus0.pready}, 32'd0);
      preset = 1'b1;
      @(posedge pclk); #1;
      check("mid_rst_pready", {31'd0, bus0.pready}, 32'd0);
      check("mid_rst_pslverr", {31'd0, bus0.pslverr}, 32'd0);
      check("mid_rst_prdata", bus0.prdata, 32'd0);
      check("mid_rst_fsm0", {29'd0, fsm0}, 32'd0);
      check("mid_rst_fsm1", {29'd0, fsm1}, 32'd0);
      bus0.psel    = 1'b0;
      bus0.penable = 1'b0;
      preset       = 1'b0;
      xfer(1'b0, 32'h0000_0030, 32'h0,         4'h0,  3'b000, 1, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0);

      repeat (4) @(posedge pclk);
      #1;
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
